// File: rtl/xbar_out_stage.sv
// xbar_out_stage: registered wormhole crossbar output stage for one router port.
// Muxes NUM_IN input channels onto one output under an encoded grant. The path
// is locked from head flit to tail flit, and the output has a valid/ready register.
// Optional feature: define XBAR_FLIT_CNT_EN to add the 16-bit flitcnt output.
module xbar_out_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_IN     = 5,
  parameter int SEL_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SEL_W-1:0]             sel_in,
  input  logic [NUM_IN*DATA_WIDTH-1:0] datain,
  input  logic [NUM_IN-1:0]            validin,
  output logic [NUM_IN-1:0]            readyin,
  output logic [DATA_WIDTH-1:0]        dataout,
  output logic                         validout,
  input  logic                         readyout,
  output logic                         lockedout,
`ifdef XBAR_FLIT_CNT_EN
  output logic [15:0]                  flitcnt,
`endif
  output logic                         errout
);

  localparam logic [1:0] FT_SINGLE = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_BODY   = 2'b10;
  localparam logic [1:0] FT_TAIL   = 2'b11;

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic                  state;
  logic [SEL_W-1:0]      lock_sel;

  logic [SEL_W-1:0]      cand_p0;
  logic                  cand_ok_p0;
  logic [DATA_WIDTH-1:0] cand_data_p0;
  logic                  cand_vld_p0;
  logic                  can_load_p0;
  logic                  grant_p0;
  logic                  xfer_p0;
  logic [1:0]            ftype_p0;
  logic                  load_p0;
  logic                  err_p0;

  // Flit type lives in the two most significant bits of every flit.
  function automatic logic [1:0] flit_type(input logic [DATA_WIDTH-1:0] f);
    return f[DATA_WIDTH-1 -: 2];
  endfunction

  // Single and head flits are the only legal way to open a packet.
  function automatic logic opens_packet(input logic [1:0] t);
    return (t == FT_SINGLE) || (t == FT_HEAD);
  endfunction

  // ---- p0: candidate selection, handshake and flit classification ----
  // Pick the candidate channel: the locked one mid-packet, else the arbiter grant.
  always_comb begin
    cand_p0      = (state == ST_LOCKED) ? lock_sel : sel_in;
    cand_ok_p0   = (state == ST_LOCKED) || (sel_in < SEL_W'(NUM_IN));
    cand_data_p0 = '0;
    cand_vld_p0  = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (cand_p0 == SEL_W'(i)) begin
        cand_data_p0 = datain[i*DATA_WIDTH +: DATA_WIDTH];
        cand_vld_p0  = validin[i];
      end
    end
  end

  assign can_load_p0 = !validout || readyout;
  assign grant_p0    = cand_ok_p0 && can_load_p0 && !rst;
  assign xfer_p0     = grant_p0 && cand_vld_p0;
  assign ftype_p0    = flit_type(cand_data_p0);

  // Stray body/tail flits in IDLE are swallowed without loading the register.
  assign load_p0 = xfer_p0 && ((state == ST_LOCKED) || opens_packet(ftype_p0));
  assign err_p0  = xfer_p0 && (((state == ST_IDLE)   && !opens_packet(ftype_p0)) ||
                               ((state == ST_LOCKED) &&  opens_packet(ftype_p0)));

  // One-hot accept toward the granted channel only.
  always_comb begin
    readyin = '0;
    if (grant_p0) begin
      for (int i = 0; i < NUM_IN; i++) begin
        readyin[i] = (cand_p0 == SEL_W'(i));
      end
    end
  end

  // ---- p1: output register, path lock and error pulse ----
  // Output register plus wormhole lock state; a reset drops any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lock_sel <= '0;
      dataout  <= '0;
      validout <= 1'b0;
      errout   <= 1'b0;
    end else begin
      errout <= err_p0;
      if (load_p0) begin
        dataout  <= cand_data_p0;
        validout <= 1'b1;
      end else if (readyout) begin
        validout <= 1'b0;
      end
      if (xfer_p0) begin
        if (state == ST_IDLE) begin
          if (ftype_p0 == FT_HEAD) begin
            state    <= ST_LOCKED;
            lock_sel <= cand_p0;
          end
        end else if (ftype_p0 == FT_TAIL) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  assign lockedout = (state == ST_LOCKED);

`ifdef XBAR_FLIT_CNT_EN
  // Count flits entering the output register; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flitcnt <= '0;
    end else if (load_p0) begin
      flitcnt <= flitcnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xbar_out_stage.sv
// tb_xbar_out_stage: directed bench for xbar_out_stage with an output scoreboard.
// Flit-counter checks are present only when XBAR_FLIT_CNT_EN is defined.
module tb_xbar_out_stage;

  localparam int DW = 32;
  localparam int NI = 5;
  localparam int SW = 3;

  localparam logic [1:0] T_S = 2'b00;
  localparam logic [1:0] T_H = 2'b01;
  localparam logic [1:0] T_B = 2'b10;
  localparam logic [1:0] T_T = 2'b11;

  logic              clk;
  logic              rst;
  logic [SW-1:0]     sel_in;
  logic [NI*DW-1:0]  datain;
  logic [NI-1:0]     validin;
  logic [NI-1:0]     readyin;
  logic [DW-1:0]     dataout;
  logic              validout;
  logic              readyout;
  logic              lockedout;
  logic              errout;
`ifdef XBAR_FLIT_CNT_EN
  logic [15:0]       flitcnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b1;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] f_h, f_b1, f_b2, f_t, f_s1, f_p1, f_p2, f_e;

  xbar_out_stage #(.DATA_WIDTH(DW), .NUM_IN(NI), .SEL_W(SW)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel_in   (sel_in),
    .datain   (datain),
    .validin  (validin),
    .readyin  (readyin),
    .dataout  (dataout),
    .validout (validout),
    .readyout (readyout),
    .lockedout(lockedout),
`ifdef XBAR_FLIT_CNT_EN
    .flitcnt  (flitcnt),
`endif
    .errout   (errout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [29:0] p);
    return {t, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [DW-1:0] v);
    datain[i*DW +: DW] = v;
  endtask

  // Scoreboard: every flit accepted downstream must match the next expected one.
  always @(negedge clk) begin
    if (mon_en && !rst && validout && readyout) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {32'd0, dataout}, 64'hDEAD);
      end else begin
        chk("sb_data", {32'd0, dataout}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    sel_in   = 3'd2;
    datain   = '0;
    validin  = 5'b00100;
    readyout = 1'b1;
    rst      = 1'b0;
    f_h  = mk(T_H, 30'h4_0001);
    f_b1 = mk(T_B, 30'h4_0002);
    f_b2 = mk(T_B, 30'h4_0003);
    f_t  = mk(T_T, 30'h4_0004);
    f_s1 = mk(T_S, 30'h1_0055);
    f_p1 = mk(T_S, 30'h0_1111);
    f_p2 = mk(T_S, 30'h0_2222);
    f_e  = mk(T_B, 30'h3_0BAD);

    // Reset state
    #1 rst = 1'b1;
    #1;
    chk("rst_validout", validout, 0);
    chk("rst_dataout", dataout, 0);
    chk("rst_lockedout", lockedout, 0);
    chk("rst_errout", errout, 0);
    chk("rst_readyin", readyin, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("idle_readyin_sel2", readyin, 5'b00100);
    sel_in = 3'd3;
    #1;
    chk("idle_readyin_sel3", readyin, 5'b01000);
    sel_in = 3'd6;
    #1;
    chk("idle_readyin_nogrant", readyin, 5'b00000);

    // Single flit on ch2
    sel_in = 3'd2;
    validin = 5'b00100;
    set_ch(2, 32'h0000_00AA);
    exp_q.push_back(32'h0000_00AA);
    tick();
    validin = 5'b00000;
    chk("single_validout", validout, 1);
    chk("single_dataout", dataout, 32'h0000_00AA);
    chk("single_lockedout", lockedout, 0);
    tick();
    chk("single_drained", validout, 0);

    // Packet on ch4; grant moves to ch1 after the head
    sel_in = 3'd4;
    validin = 5'b10000;
    set_ch(4, f_h);
    exp_q.push_back(f_h);
    tick();
    chk("pkt_lock_h", lockedout, 1);
    sel_in = 3'd1;
    set_ch(1, f_s1);
    validin = 5'b10010;
    set_ch(4, f_b1);
    #1;
    chk("pkt_readyin_locked", readyin, 5'b10000);
    exp_q.push_back(f_b1);
    tick();
    chk("pkt_lock_b1", lockedout, 1);
    chk("pkt_valid_b1", validout, 1);
    set_ch(4, f_b2);
    exp_q.push_back(f_b2);
    tick();
    chk("pkt_lock_b2", lockedout, 1);
    chk("pkt_data_b2", dataout, f_b2);
    set_ch(4, f_t);
    exp_q.push_back(f_t);
    tick();
    chk("pkt_unlock_t", lockedout, 0);
    chk("pkt_data_t", dataout, f_t);
    validin = 5'b00010;
    #1;
    chk("pkt_then_ch1_ready", readyin, 5'b00010);
    exp_q.push_back(f_s1);
    tick();
    validin = 5'b00000;
    chk("pkt_ch1_data", dataout, f_s1);
    tick();

    // Backpressure
    sel_in = 3'd0;
    set_ch(0, f_p1);
    validin = 5'b00001;
    exp_q.push_back(f_p1);
    tick();
    set_ch(0, f_p2);
    readyout = 1'b0;
    #1;
    chk("bp_readyin0", readyin, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_data", dataout, f_p1);
      chk("bp_hold_valid", validout, 1);
      chk("bp_readyin", readyin, 0);
    end
    readyout = 1'b1;
    #1;
    chk("bp_release_ready", readyin, 5'b00001);
    exp_q.push_back(f_p2);
    tick();
    validin = 5'b00000;
    chk("bp_nobubble_data", dataout, f_p2);
    chk("bp_nobubble_valid", validout, 1);
    tick();
    chk("bp_drained", validout, 0);

    // Body flit offered in IDLE: consumed, dropped, error pulse
    sel_in = 3'd3;
    set_ch(3, f_e);
    validin = 5'b01000;
    #1;
    chk("err_body_ready", readyin, 5'b01000);
    tick();
    validin = 5'b00000;
    chk("err_body_pulse", errout, 1);
    chk("err_body_noload", validout, 0);
    chk("err_body_idle", lockedout, 0);
    tick();
    chk("err_body_pulse_end", errout, 0);

    // Head offered while LOCKED: forwarded with error
    sel_in = 3'd2;
    validin = 5'b00100;
    set_ch(2, mk(T_H, 30'h2_0001));
    exp_q.push_back(mk(T_H, 30'h2_0001));
    tick();
    chk("err_head_lock", lockedout, 1);
    chk("err_head_noerr", errout, 0);
    set_ch(2, mk(T_H, 30'h2_0002));
    exp_q.push_back(mk(T_H, 30'h2_0002));
    tick();
    chk("err_head_pulse", errout, 1);
    chk("err_head_stay", lockedout, 1);
    chk("err_head_fwd", dataout, mk(T_H, 30'h2_0002));
    set_ch(2, mk(T_T, 30'h2_0003));
    exp_q.push_back(mk(T_T, 30'h2_0003));
    tick();
    validin = 5'b00000;
    chk("err_head_pulse_end", errout, 0);
    chk("err_head_unlock", lockedout, 0);
    tick();

    // Mid-packet reset
    sel_in = 3'd1;
    set_ch(1, mk(T_H, 30'h1_0001));
    validin = 5'b00010;
    exp_q.push_back(mk(T_H, 30'h1_0001));
    tick();
    chk("mid_locked", lockedout, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", validout, 0);
    chk("mid_rst_data", dataout, 0);
    chk("mid_rst_lock", lockedout, 0);
    chk("mid_rst_ready", readyin, 0);
    tick();
    rst = 1'b0;
    validin = 5'b00000;
    sel_in = 3'd3;
    #1;
    chk("mid_after_idle_ready", readyin, 5'b01000);
    chk("mid_after_lock", lockedout, 0);
    tick();

`ifdef XBAR_FLIT_CNT_EN
    // Flit counter wrap
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("cnt_rst", flitcnt, 0);
    tick();
    rst = 1'b0;
    sel_in = 3'd0;
    set_ch(0, mk(T_S, 30'h0_0C0C));
    validin = 5'b00001;
    for (int k = 0; k < 65535; k++) tick();
    chk("cnt_ffff", flitcnt, 16'hFFFF);
    tick();
    validin = 5'b00000;
    chk("cnt_wrap", flitcnt, 16'h0000);
    tick();
    tick();
`endif

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
